// File: rtl/mio_pkg.sv
// Shared definitions for the CPU memory/IO responder: FSM states, IO region default
// and the data pattern returned by a timed-out IO read.
package mio_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RAM_WAIT = 2'd1,
      IO_WAIT  = 2'd2,
      RESP     = 2'd3
   } state_t;

   localparam logic [3:0]  IO_BASE_NIB_DEF = 4'hF;
   localparam logic [31:0] ERR_PATTERN     = 32'hDEAD_BEEF;

endpackage

// File: rtl/mio_ram.sv
// Single-port synchronous word RAM; dout holds the word at the index sampled on the
// previous edge. Contents are never reset.
module mio_ram #(
   parameter int AW = 10,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] index,
   input  logic [DW-1:0] din,
   output logic [DW-1:0] dout
);

   logic [DW-1:0] mem [0:(1<<AW)-1];

   always_ff @(posedge clk) begin
      if (we)
         mem[index] <= din;
      dout <= mem[index];
   end

endmodule

// File: rtl/mio_ctrl.sv
// Responder for the multi-cycle CPU memory/IO handshake: decodes requests to internal
// RAM or the IO bus. Optional IO timeout with sticky bus_err is enabled by MIO_TIMEOUT_EN.
module mio_ctrl
   import mio_pkg::*;
#(
   parameter int         RAM_AW      = 10,
   parameter int         RAM_LAT     = 2,
   parameter logic [3:0] IO_BASE_NIB = IO_BASE_NIB_DEF,
   parameter int         IO_TIMEOUT  = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        MIO_ready,
   output logic [31:0] io_addr,
   output logic [31:0] io_wdata,
   output logic        io_re,
   output logic        io_we,
   input  logic [31:0] io_rdata,
   input  logic        io_ack,
   output logic        bus_err
);

   localparam int CNT_MAX = (RAM_LAT > IO_TIMEOUT) ? RAM_LAT : IO_TIMEOUT;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   state_t              state;
   logic [CNT_W-1:0]    cnt;
   logic                op_wr;
   logic [RAM_AW-1:0]   ram_idx;
   logic [31:0]         wdata_q;
   logic [RAM_AW-1:0]   ram_index;
   logic                ram_we;
   logic [31:0]         ram_dout;

`ifdef MIO_TIMEOUT_EN
   logic bus_err_q;
   assign bus_err = bus_err_q;
`else
   assign bus_err = 1'b0;
`endif

   // In IDLE the RAM already looks at the live address so read data is ready by the time
   // the latency count expires, even for RAM_LAT=1.
   assign ram_index = (state == IDLE) ? addr[RAM_AW+1:2] : ram_idx;
   assign ram_we    = (state == RAM_WAIT) && (cnt == '0) && op_wr;

   mio_ram #(
      .AW (RAM_AW),
      .DW (32)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .index (ram_index),
      .din   (wdata_q),
      .dout  (ram_dout)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         op_wr     <= 1'b0;
         ram_idx   <= '0;
         wdata_q   <= '0;
         rdata     <= '0;
         MIO_ready <= 1'b0;
         io_addr   <= '0;
         io_wdata  <= '0;
         io_re     <= 1'b0;
         io_we     <= 1'b0;
`ifdef MIO_TIMEOUT_EN
         bus_err_q <= 1'b0;
`endif
      end else begin
         MIO_ready <= 1'b0;
         case (state)
            IDLE: begin
               if (MemRead || MemWrite) begin
                  op_wr <= MemWrite;
                  if (addr[31:28] == IO_BASE_NIB) begin
                     io_addr  <= addr;
                     io_wdata <= wdata;
                     io_we    <= MemWrite;
                     io_re    <= ~MemWrite;
                     cnt      <= CNT_W'(IO_TIMEOUT - 1);
                     state    <= IO_WAIT;
                  end else begin
                     ram_idx <= addr[RAM_AW+1:2];
                     wdata_q <= wdata;
                     cnt     <= CNT_W'(RAM_LAT - 1);
                     state   <= RAM_WAIT;
                  end
               end
            end
            RAM_WAIT: begin
               if (cnt == '0) begin
                  if (!op_wr)
                     rdata <= ram_dout;
                  MIO_ready <= 1'b1;
                  state     <= RESP;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            IO_WAIT: begin
               if (io_ack) begin
                  if (!op_wr)
                     rdata <= io_rdata;
                  io_re     <= 1'b0;
                  io_we     <= 1'b0;
                  MIO_ready <= 1'b1;
                  state     <= RESP;
               end
`ifdef MIO_TIMEOUT_EN
               else if (cnt == '0) begin
                  if (!op_wr)
                     rdata <= ERR_PATTERN;
                  io_re     <= 1'b0;
                  io_we     <= 1'b0;
                  bus_err_q <= 1'b1;
                  MIO_ready <= 1'b1;
                  state     <= RESP;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
`endif
            end
            RESP: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mio_ctrl.sv
// Self-checking bench for mio_ctrl: directed cases plus randomized RAM/IO traffic
// compared against a word-array memory model and latency rules.
module tb_mio_ctrl;

   localparam int RAM_AW     = 10;
   localparam int RAM_LAT    = 2;
   localparam int IO_TIMEOUT = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic        MemRead, MemWrite;
   logic [31:0] addr, wdata, rdata;
   logic        MIO_ready;
   logic [31:0] io_addr, io_wdata, io_rdata;
   logic        io_re, io_we, io_ack, bus_err;

   int testCount = 0;
   int failCount = 0;

   logic [31:0] memModel [0:(1<<RAM_AW)-1];
   bit          memValid [0:(1<<RAM_AW)-1];
   logic [31:0] rdataModel;
   logic [31:0] busErrModel;

   mio_ctrl #(
      .RAM_AW      (RAM_AW),
      .RAM_LAT     (RAM_LAT),
      .IO_BASE_NIB (4'hF),
      .IO_TIMEOUT  (IO_TIMEOUT)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .MemRead   (MemRead),
      .MemWrite  (MemWrite),
      .addr      (addr),
      .wdata     (wdata),
      .rdata     (rdata),
      .MIO_ready (MIO_ready),
      .io_addr   (io_addr),
      .io_wdata  (io_wdata),
      .io_re     (io_re),
      .io_we     (io_we),
      .io_rdata  (io_rdata),
      .io_ack    (io_ack),
      .bus_err   (bus_err)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
      end
   endtask

   task automatic checkResetState();
      checkOutput("rst_rdata", rdata, 32'h0);
      checkOutput("rst_ready", {31'b0, MIO_ready}, 32'h0);
      checkOutput("rst_io_re", {31'b0, io_re}, 32'h0);
      checkOutput("rst_io_we", {31'b0, io_we}, 32'h0);
      checkOutput("rst_io_addr", io_addr, 32'h0);
      checkOutput("rst_io_wdata", io_wdata, 32'h0);
      checkOutput("rst_bus_err", {31'b0, bus_err}, 32'h0);
   endtask

   // One CPU access; ackDelay < 0 means the IO side never acknowledges.
   task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] a,
                                input logic [31:0] d, input int ackDelay, input logic [31:0] ioData);
      bit isIo = (a[31:28] == 4'hF);
      bit isWr = wr;
      int idx  = int'(a[RAM_AW+1:2]);
      int expLat;
      int n = 0;
      bit done = 0;
      if (isIo)
         expLat = (ackDelay < 0) ? IO_TIMEOUT + 1 : 2 + ackDelay;
      else
         expLat = RAM_LAT + 1;
      MemRead  = rd;
      MemWrite = wr;
      addr     = a;
      wdata    = d;
      while (!done && n < 80) begin
         @(negedge clk);
         n++;
         if (MIO_ready) begin
            done = 1;
            checkOutput("latency", n, expLat);
            if (isWr) begin
               if (!isIo) begin
                  memModel[idx] = d;
                  memValid[idx] = 1;
               end
            end else if (isIo) begin
               rdataModel = (ackDelay < 0) ? 32'hDEAD_BEEF : ioData;
            end else begin
               rdataModel = memModel[idx];
            end
            if (isIo && ackDelay < 0)
               busErrModel = 32'h1;
            checkOutput("rdata", rdata, rdataModel);
            checkOutput("bus_err", {31'b0, bus_err}, busErrModel);
            checkOutput("io_re_drop", {31'b0, io_re}, 32'h0);
            checkOutput("io_we_drop", {31'b0, io_we}, 32'h0);
            MemRead  = 1'b0;
            MemWrite = 1'b0;
            io_ack   = 1'b0;
            io_rdata = $urandom;
         end else begin
            if (n == 1) begin
               addr  = $urandom;
               wdata = $urandom;
            end
            if (isIo) begin
               checkOutput("io_re", {31'b0, io_re}, {31'b0, ~isWr});
               checkOutput("io_we", {31'b0, io_we}, {31'b0, isWr});
               if (n == 1) begin
                  checkOutput("io_addr", io_addr, a);
                  checkOutput("io_wdata", io_wdata, d);
               end
               if (ackDelay >= 0 && n == 1 + ackDelay) begin
                  io_ack   = 1'b1;
                  io_rdata = ioData;
               end else begin
                  io_ack   = 1'b0;
                  io_rdata = $urandom;
               end
            end
         end
      end
      if (!done) begin
         checkOutput("ready_timeout", 32'h0, 32'h1);
         MemRead  = 1'b0;
         MemWrite = 1'b0;
         io_ack   = 1'b0;
      end
      @(negedge clk);
      checkOutput("ready_pulse", {31'b0, MIO_ready}, 32'h0);
   endtask

   initial begin
      logic [31:0] a;
      logic [31:0] d;
      for (int i = 0; i < (1<<RAM_AW); i++)
         memValid[i] = 0;
      rdataModel  = 32'h0;
      busErrModel = 32'h0;
      reset    = 1'b1;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      addr     = 32'h0;
      wdata    = 32'h0;
      io_rdata = 32'h0;
      io_ack   = 1'b0;
      repeat (3) @(negedge clk);
      checkResetState();
      reset = 1'b0;
      @(negedge clk);

      applyStimulus(1'b0, 1'b1, 32'h0000_0010, 32'h1234_5678, 0, 32'h0);
      applyStimulus(1'b1, 1'b0, 32'h0000_0010, 32'h0, 0, 32'h0);
      applyStimulus(1'b0, 1'b1, 32'h0000_1010, 32'hAAAA_5555, 0, 32'h0);
      applyStimulus(1'b1, 1'b0, 32'h0000_0013, 32'h0, 0, 32'h0);
      applyStimulus(1'b1, 1'b0, 32'hF000_0004, 32'h0, 5, 32'hCAFE_0001);
      applyStimulus(1'b1, 1'b0, 32'h0000_0010, 32'h0, 0, 32'h0);
      applyStimulus(1'b1, 1'b1, 32'h0000_0020, 32'h0F0F_0F0F, 0, 32'h0);
      applyStimulus(1'b1, 1'b0, 32'h0000_0020, 32'h0, 0, 32'h0);

      io_ack   = 1'b1;
      io_rdata = 32'h1111_2222;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput("idle_ack_ready", {31'b0, MIO_ready}, 32'h0);
         checkOutput("idle_ack_rdata", rdata, rdataModel);
      end
      io_ack = 1'b0;
      @(negedge clk);

      MemWrite = 1'b1;
      addr     = 32'h0000_0010;
      wdata    = 32'h5555_AAAA;
      @(negedge clk);
      reset = 1'b1;
      #1;
      checkResetState();
      rdataModel  = 32'h0;
      busErrModel = 32'h0;
      MemWrite = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      applyStimulus(1'b1, 1'b0, 32'h0000_0010, 32'h0, 0, 32'h0);

`ifdef MIO_TIMEOUT_EN
      applyStimulus(1'b1, 1'b0, 32'hF000_0100, 32'h0, -1, 32'h0);
      applyStimulus(1'b1, 1'b0, 32'h0000_0020, 32'h0, 0, 32'h0);
      applyStimulus(1'b0, 1'b1, 32'hF000_0200, 32'h1357_9BDF, 2, 32'h0);
      reset = 1'b1;
      #1;
      checkResetState();
      rdataModel  = 32'h0;
      busErrModel = 32'h0;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
`endif

      for (int t = 0; t < 40; t++) begin
         bit doIo  = ($urandom_range(0, 3) == 0);
         int kind  = $urandom_range(0, 2);
         bit rd    = (kind != 1);
         bit wr    = (kind != 0);
         d = $urandom;
         if (doIo) begin
            a = {4'hF, 28'($urandom)};
         end else begin
            a = {4'($urandom_range(0, 14)), 28'($urandom)};
            if (!wr && !memValid[a[RAM_AW+1:2]])
               wr = 1;
         end
         applyStimulus(rd, wr, a, d, $urandom_range(0, 6), $urandom);
      end

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
